writeback_stage: RTL and testbench

Final pipeline stage of the pipelined RV32I core, and the write side of the Decode-stage register file. Captures the MEM-stage result into the MEM/WB pipeline register. Selects and formats the value to retire: ALU result, sign/zero-extended load data, or PC+4 for jumps. Drives the register-file write port, and counts retired instructions in a 64-bit counter.

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/load_extend.sv | 29 ++
 rtl/writeback_stage.sv | 76 +++++++
 tb/tb_writeback_stage.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I constants for the pipeline stages
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - selects the addressed byte/halfword lane and extends it
module load_extend
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        byte_lane = word[{offset, 3'b000} +: 8];
        // Halfword lane depends only on offset[1]; a misaligned offset[0] is ignored.
        half_lane = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_lane[7]}}, byte_lane};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_lane};
            F3_LH:   data = {{(XLEN-16){half_lane[15]}}, half_lane};
            F3_LHU:  data = {{(XLEN-16){1'b0}}, half_lane};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - MEM/WB register, result select, regfile write port, instret
module writeback_stage
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_valid,
    input  logic             mem_RegWrite,
    input  logic             mem_MemtoReg,
    input  logic             mem_Jump,
    input  logic [4:0]       mem_rd,
    input  logic [2:0]       mem_funct3,
    input  logic [XLEN-1:0]  mem_alu_result,
    input  logic [XLEN-1:0]  mem_load_data,
    input  logic [XLEN-1:0]  mem_pc_plus4,
    input  logic             stall,
    input  logic             flush,
    output logic [4:0]       reg_write_addr,
    output logic [XLEN-1:0]  reg_write_data,
    output logic             RegWrite_WB,
    output logic             wb_valid,
    output logic [CNT_W-1:0] instret
);

    logic            valid_q;
    logic            regwrite_q;
    logic [4:0]      rd_q;
    logic [XLEN-1:0] result_q;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] result_d;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3 (mem_funct3),
        .offset (mem_alu_result[1:0]),
        .word   (mem_load_data),
        .data   (load_ext)
    );

    // Jump wins over MemtoReg so JALR never retires a stray load value.
    always_comb begin
        result_d = mem_alu_result;
        if (mem_Jump)
            result_d = mem_pc_plus4;
        else if (mem_MemtoReg)
            result_d = load_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= 5'd0;
            result_q   <= '0;
            instret    <= '0;
        end else if (flush) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
        end else if (!stall) begin
            valid_q    <= mem_valid;
            regwrite_q <= mem_RegWrite;
            rd_q       <= mem_rd;
            result_q   <= result_d;
            if (mem_valid)
                instret <= instret + CNT_W'(1);
        end
    end

    assign reg_write_addr = rd_q;
    assign reg_write_data = result_q;
    assign RegWrite_WB    = valid_q & regwrite_q & (rd_q != 5'd0);
    assign wb_valid       = valid_q;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - randomized and directed checks of writeback_stage
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_RegWrite, mem_MemtoReg, mem_Jump;
    logic [4:0]  mem_rd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_alu_result, mem_load_data, mem_pc_plus4;
    logic        stall, flush;
    logic [4:0]  reg_write_addr;
    logic [31:0] reg_write_data;
    logic        RegWrite_WB, wb_valid;
    logic [63:0] instret;
    logic [4:0]  s_addr;
    logic [31:0] s_data;
    logic        s_rw, s_valid;
    logic [3:0]  s_instret;

    writeback_stage #(.XLEN(32), .CNT_W(64)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
        .mem_MemtoReg(mem_MemtoReg), .mem_Jump(mem_Jump), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .stall(stall), .flush(flush), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data), .RegWrite_WB(RegWrite_WB),
        .wb_valid(wb_valid), .instret(instret)
    );

    writeback_stage #(.XLEN(32), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_RegWrite(mem_RegWrite),
        .mem_MemtoReg(mem_MemtoReg), .mem_Jump(mem_Jump), .mem_rd(mem_rd),
        .mem_funct3(mem_funct3), .mem_alu_result(mem_alu_result),
        .mem_load_data(mem_load_data), .mem_pc_plus4(mem_pc_plus4),
        .stall(stall), .flush(flush), .reg_write_addr(s_addr),
        .reg_write_data(s_data), .RegWrite_WB(s_rw),
        .wb_valid(s_valid), .instret(s_instret)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned passed = 0;

    // Reference state: what the write port should show after each edge.
    bit          m_valid, m_rw, m_dc;
    logic [4:0]  m_rd;
    logic [31:0] m_res;
    logic [63:0] m_cnt;
    int          m_cnt_s;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        longint b, h;
        b = (longint'(w) >> (8 * a)) & 255;
        h = (longint'(w) >> (16 * a[1])) & 65535;
        case (f3)
            3'b000:  return 32'((b >= 128) ? b - 256 : b);
            3'b100:  return 32'(b);
            3'b001:  return 32'((h >= 32768) ? h - 65536 : h);
            3'b101:  return 32'(h);
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_result();
        if (mem_Jump) return mem_pc_plus4;
        if (mem_MemtoReg) return ref_load(mem_funct3, mem_alu_result[1:0], mem_load_data);
        return mem_alu_result;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_dc = 0; m_rd = 0; m_res = 0; m_cnt = 0; m_cnt_s = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) begin
            if (flush) begin
                m_valid = 0; m_rw = 0; m_dc = 1;
            end else if (!stall) begin
                m_valid = mem_valid; m_rw = mem_RegWrite; m_rd = mem_rd;
                m_res = ref_result(); m_dc = 0;
                if (mem_valid) begin
                    m_cnt = m_cnt + 1;
                    m_cnt_s = (m_cnt_s + 1) % 16;
                end
            end
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, ".wb_valid"}, 64'(wb_valid), 64'(m_valid));
        check({tag, ".RegWrite_WB"}, 64'(RegWrite_WB), 64'(m_valid && m_rw && m_rd != 0));
        if (!m_dc) begin
            check({tag, ".addr"}, 64'(reg_write_addr), 64'(m_rd));
            check({tag, ".data"}, 64'(reg_write_data), 64'(m_res));
        end
        check({tag, ".instret"}, instret, m_cnt);
        check({tag, ".instret_s"}, 64'(s_instret), 64'(m_cnt_s));
    endtask

    task automatic rand_inputs();
        mem_valid = 1'($urandom); mem_RegWrite = 1'($urandom);
        mem_MemtoReg = 1'($urandom); mem_Jump = 1'($urandom);
        mem_rd = 5'($urandom); mem_funct3 = 3'($urandom);
        mem_alu_result = $urandom; mem_load_data = $urandom; mem_pc_plus4 = $urandom;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] v);
        mem_valid = 1; mem_RegWrite = 1; mem_MemtoReg = 0; mem_Jump = 0;
        mem_rd = rd; mem_alu_result = v; stall = 0; flush = 0;
    endtask

    logic [2:0]  d_f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011};
    logic [1:0]  d_a  [6] = '{2'd3, 2'd2, 2'd2, 2'd0, 2'd1, 2'd3};
    logic [31:0] d_exp[6] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                              32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};

    initial begin
        logic [31:0] held_data;
        // Reset with random inputs
        rst = 0; stall = 0; flush = 0;
        rand_inputs();
        model_reset();
        #2;
        tick(); tick();
        check("reset.wb_valid", 64'(wb_valid), 0);
        check("reset.RegWrite_WB", 64'(RegWrite_WB), 0);
        check("reset.addr", 64'(reg_write_addr), 0);
        check("reset.data", 64'(reg_write_data), 0);
        check("reset.instret", instret, 0);

        rst = 1;
        set_alu(5'd5, 32'h0000_1234);
        tick();
        check_model("first");
        check("first.RegWrite_WB", 64'(RegWrite_WB), 1);
        check("first.addr", 64'(reg_write_addr), 5);
        check("first.data", 64'(reg_write_data), 64'h1234);
        check("first.instret", instret, 1);

        // Load formatting: full funct3/offset sweep against the model
        mem_load_data = 32'h80FF_7F01; mem_MemtoReg = 1;
        for (int f = 0; f < 8; f++) begin
            for (int a = 0; a < 4; a++) begin
                mem_funct3 = 3'(f);
                mem_alu_result = {$urandom, 2'b00} | 32'(a);
                mem_rd = 5'($urandom_range(1, 31));
                tick();
                check_model("load_sweep");
            end
        end
        for (int i = 0; i < 6; i++) begin
            mem_funct3 = d_f3[i];
            mem_alu_result = 32'h0000_1000 | 32'(d_a[i]);
            tick();
            check("load_directed", 64'(reg_write_data), 64'(d_exp[i]));
        end

        mem_Jump = 1; mem_MemtoReg = 1; mem_pc_plus4 = 32'h0000_0104;
        tick();
        check("jump_priority", 64'(reg_write_data), 64'h104);
        check_model("jump");

        set_alu(5'd0, 32'hDEAD_BEEF);
        tick();
        check("x0.RegWrite_WB", 64'(RegWrite_WB), 0);
        check("x0.wb_valid", 64'(wb_valid), 1);
        check_model("x0");

        // Stall holds everything
        set_alu(5'd7, 32'h0BAD_F00D);
        tick();
        held_data = reg_write_data;
        check("stall_cap.data", 64'(held_data), 64'h0BAD_F00D);
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); stall = 1;
            tick();
            check("stall.addr", 64'(reg_write_addr), 7);
            check("stall.data", 64'(reg_write_data), 64'h0BAD_F00D);
            check("stall.RegWrite_WB", 64'(RegWrite_WB), 1);
            check_model("stall");
        end
        flush = 1; stall = 1; mem_valid = 1;
        tick();
        check("flush.wb_valid", 64'(wb_valid), 0);
        check("flush.RegWrite_WB", 64'(RegWrite_WB), 0);
        check_model("flush");

        // Bubble and back-to-back same-rd writes
        flush = 0; stall = 0; mem_valid = 0;
        tick();
        check_model("bubble");
        set_alu(5'd9, 32'h1111_1111);
        tick(); check_model("b2b1");
        mem_alu_result = 32'h2222_2222;
        tick(); check_model("b2b2");

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick();
            check_model("random");
        end

        // Drive the 4-bit counter to all-ones, then one capture wraps it
        set_alu(5'd3, 32'h5);
        for (int i = 0; i < 16 && m_cnt_s != 15; i++) tick();
        check("wrap_pre", 64'(s_instret), 15);
        tick();
        check("wrap", 64'(s_instret), 0);
        check_model("wrap");

        // Async reset mid-stall, observed before the next edge
        stall = 1;
        tick();
        rst = 0;
        model_reset();
        #1;
        check("async.wb_valid", 64'(wb_valid), 0);
        check("async.RegWrite_WB", 64'(RegWrite_WB), 0);
        check("async.addr", 64'(reg_write_addr), 0);
        check("async.data", 64'(reg_write_data), 0);
        check("async.instret", instret, 0);
        check("async.instret_s", 64'(s_instret), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
